// File: rtl/hex_ascii_byte_rx_if.sv
// Character-in / byte-out bus for the ASCII hex receive decoder.
// The slave view is the decoder; the master view is its character source and byte consumer.
interface hex_ascii_byte_rx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       pending;
  logic       err_invalid;
  logic       err_overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, pending, err_invalid, err_overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, pending, err_invalid, err_overflow
  );
endinterface

// File: rtl/hex_ascii_byte_rx.sv
// Decodes pairs of ASCII hex digits (high nibble first) into bytes on a valid/ready register.
// A separator after a lone digit completes the byte as 0x0N; a stale lone digit can time out.
module hex_ascii_byte_rx #(
  parameter bit          ALLOW_LOWERCASE = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 0
) (
  input logic               clk,
  input logic               resetn,
  hex_ascii_byte_rx_if.slave bus
);

  localparam int unsigned CNT_W = 24;
  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_HAVE_HI = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       nib_q, nib_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             err_inv_q, err_inv_d;
  logic             err_ovf_q, err_ovf_d;

  logic             is_digit_c;
  logic             is_sep_c;
  logic [3:0]       nib_c;
  logic             emit_c;
  logic [7:0]       emit_byte_c;

  // Character classification
  always_comb begin
    is_digit_c = 1'b0;
    is_sep_c   = 1'b0;
    nib_c      = 4'h0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      is_digit_c = 1'b1;
      nib_c      = 4'(bus.in_data - 8'h30);
    end else if (bus.in_data >= 8'h41 && bus.in_data <= 8'h46) begin
      is_digit_c = 1'b1;
      nib_c      = 4'(bus.in_data - 8'h37);
    end else if (ALLOW_LOWERCASE && bus.in_data >= 8'h61 && bus.in_data <= 8'h66) begin
      is_digit_c = 1'b1;
      nib_c      = 4'(bus.in_data - 8'h57);
    end else begin
      case (bus.in_data)
        8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C: is_sep_c = 1'b1;
        default:                           is_sep_c = 1'b0;
      endcase
    end
  end

  // Next state, nibble latch, idle timeout and emit decision
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    cnt_d       = cnt_q;
    err_inv_d   = 1'b0;
    emit_c      = 1'b0;
    emit_byte_c = 8'h00;
    if (bus.in_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_EMPTY: begin
          if (is_digit_c) begin
            nib_d   = nib_c;
            state_d = ST_HAVE_HI;
          end else if (!is_sep_c) begin
            err_inv_d = 1'b1;
          end
        end
        ST_HAVE_HI: begin
          state_d = ST_EMPTY;
          if (is_digit_c) begin
            emit_c      = 1'b1;
            emit_byte_c = {nib_q, nib_c};
          end else if (is_sep_c) begin
            emit_c      = 1'b1;
            emit_byte_c = {4'h0, nib_q};
          end else begin
            err_inv_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else if (state_q == ST_HAVE_HI) begin
      // Drop the lone digit once TIMEOUT_CYCLES idle cycles have elapsed
      if (TIMEOUT_CYCLES != 0 && (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output register: load, consume-and-reload, drop on full, or drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_ovf_d   = 1'b0;
    if (emit_c) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = emit_byte_c;
      end else begin
        err_ovf_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_EMPTY;
      nib_q       <= 4'h0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      err_inv_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_inv_q   <= err_inv_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.pending      = (state_q == ST_HAVE_HI);
  assign bus.err_invalid  = err_inv_q;
  assign bus.err_overflow = err_ovf_q;

endmodule

// File: tb/tb_hex_ascii_byte_rx.sv
// Drives two decoder builds (lowercase + 100-cycle timeout, uppercase-only + no timeout)
// with identical character streams and compares both against a per-cycle behavioural model.
module tb_hex_ascii_byte_rx;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hex_ascii_byte_rx_if ifa ();
  hex_ascii_byte_rx_if ifb ();

  hex_ascii_byte_rx #(.ALLOW_LOWERCASE(1'b1), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa)
  );
  hex_ascii_byte_rx #(.ALLOW_LOWERCASE(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model state per build: index 0 = dut_a, 1 = dut_b
  bit       m_have [2];
  int       m_hi   [2];
  int       m_idle [2];
  bit       m_ov   [2];
  bit [7:0] m_od   [2];
  bit       m_ei   [2];
  bit       m_eo   [2];

  // Digit value 0..15, -1 for a separator, -2 for anything else
  function automatic int decode(input logic [7:0] c, input bit lc);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (lc && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A || c == 8'h2C) return -1;
    return -2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 0; m_hi[i] = 0; m_idle[i] = 0;
      m_ov[i] = 0; m_od[i] = 8'h00; m_ei[i] = 0; m_eo[i] = 0;
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] c, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      bit       lc   = (i == 0);
      int       tout = (i == 0) ? 100 : 0;
      bit       emit = 0;
      bit [7:0] b    = 8'h00;
      int       d;
      m_ei[i] = 0;
      m_eo[i] = 0;
      if (v) begin
        d = decode(c, lc);
        m_idle[i] = 0;
        if (!m_have[i]) begin
          if (d >= 0) begin m_have[i] = 1; m_hi[i] = d; end
          else if (d == -2) m_ei[i] = 1;
        end else begin
          m_have[i] = 0;
          if (d >= 0) begin emit = 1; b = 8'(m_hi[i] * 16 + d); end
          else if (d == -1) begin emit = 1; b = 8'(m_hi[i]); end
          else m_ei[i] = 1;
        end
      end else if (m_have[i]) begin
        m_idle[i]++;
        if (tout != 0 && m_idle[i] == tout) begin m_have[i] = 0; m_idle[i] = 0; end
      end
      if (emit) begin
        if (!m_ov[i] || rdy) begin m_ov[i] = 1; m_od[i] = b; end
        else m_eo[i] = 1;
      end else if (m_ov[i] && rdy) begin
        m_ov[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.out_valid", 8'(ifa.out_valid),    8'(m_ov[0]));
    chk("a.out_data",  ifa.out_data,          m_od[0]);
    chk("a.pending",   8'(ifa.pending),       8'(m_have[0]));
    chk("a.err_inv",   8'(ifa.err_invalid),   8'(m_ei[0]));
    chk("a.err_ovf",   8'(ifa.err_overflow),  8'(m_eo[0]));
    chk("b.out_valid", 8'(ifb.out_valid),    8'(m_ov[1]));
    chk("b.out_data",  ifb.out_data,          m_od[1]);
    chk("b.pending",   8'(ifb.pending),       8'(m_have[1]));
    chk("b.err_inv",   8'(ifb.err_invalid),   8'(m_ei[1]));
    chk("b.err_ovf",   8'(ifb.err_overflow),  8'(m_eo[1]));
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later
  task automatic step(input bit v, input logic [7:0] c, input bit rdy);
    ifa.in_valid = v; ifa.in_data = c; ifa.out_ready = rdy;
    ifb.in_valid = v; ifb.in_data = c; ifb.out_ready = rdy;
    @(posedge clk);
    model_edge(v, c, rdy);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] c, input bit rdy);
    step(1'b1, c, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic pulse_reset();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_all();
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    int r = $urandom_range(0, 9);
    if (r < 5) begin
      k = $urandom_range(0, 21);
      if (k < 10) return 8'(48 + k);
      if (k < 16) return 8'(65 + k - 10);
      return 8'(97 + k - 16);
    end
    if (r < 7) begin
      k = $urandom_range(0, 4);
      case (k)
        0: return 8'h20;
        1: return 8'h09;
        2: return 8'h0D;
        3: return 8'h0A;
        default: return 8'h2C;
      endcase
    end
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.out_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset.a.out_data", ifa.out_data, 8'h00);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // "41" with consumer ready
    send("4", 1'b1);
    chk("t1.pending", 8'(ifa.pending), 8'h01);
    send("1", 1'b1);
    chk("t1.data", ifa.out_data, 8'h41);
    chk("t1.valid", 8'(ifa.out_valid), 8'h01);
    idle(1, 1'b1);
    chk("t1.drain", 8'(ifa.out_valid), 8'h00);

    // Lowercase accepted on a, rejected on b
    send("a", 1'b1);
    chk("t2.b_inv", 8'(ifb.err_invalid), 8'h01);
    chk("t2.b_pend", 8'(ifb.pending), 8'h00);
    send("F", 1'b1);
    chk("t2.a_data", ifa.out_data, 8'hAF);
    send("0", 1'b1);
    chk("t2.b_data", ifb.out_data, 8'hF0);
    send(" ", 1'b1);
    idle(2, 1'b1);

    // Separator completes a lone digit; lone separators do nothing
    send("7", 1'b1);
    send(8'h0D, 1'b1);
    chk("t3.data", ifa.out_data, 8'h07);
    idle(1, 1'b1);
    send(" ", 1'b1);
    send(",", 1'b1);
    chk("t3.sep_valid", 8'(ifa.out_valid), 8'h00);
    chk("t3.sep_err", 8'(ifa.err_invalid), 8'h00);

    // Invalid second character discards the high nibble
    send("3", 1'b1);
    send("G", 1'b1);
    chk("t4.inv", 8'(ifa.err_invalid), 8'h01);
    chk("t4.pend", 8'(ifa.pending), 8'h00);
    send("1", 1'b1);
    chk("t4.inv_once", 8'(ifa.err_invalid), 8'h00);
    send("2", 1'b1);
    chk("t4.data", ifa.out_data, 8'h12);
    idle(1, 1'b1);

    // Overflow with consumer stalled, then consume-and-reload at the same edge
    send("1", 1'b0); send("1", 1'b0);
    send("2", 1'b0); send("2", 1'b0);
    chk("t5.ovf", 8'(ifa.err_overflow), 8'h01);
    chk("t5.held", ifa.out_data, 8'h11);
    idle(1, 1'b0);
    chk("t5.ovf_once", 8'(ifa.err_overflow), 8'h00);
    idle(1, 1'b1);
    chk("t5.consumed", 8'(ifa.out_valid), 8'h00);
    send("4", 1'b0); send("4", 1'b0);
    send("3", 1'b0); send("3", 1'b1);
    chk("t5.reload", ifa.out_data, 8'h33);
    chk("t5.no_ovf", 8'(ifa.err_overflow), 8'h00);
    idle(1, 1'b1);

    // Timeout boundary on a (100 idle cycles); b holds its nibble
    send("5", 1'b1);
    idle(99, 1'b1);
    chk("t6.pend_99", 8'(ifa.pending), 8'h01);
    idle(1, 1'b1);
    chk("t6.pend_100", 8'(ifa.pending), 8'h00);
    chk("t6.b_hold", 8'(ifb.pending), 8'h01);
    send("6", 1'b1);
    send("7", 1'b1);
    chk("t6.data", ifa.out_data, 8'h67);
    send(" ", 1'b1);
    idle(1, 1'b1);

    // Reset mid-operation drops the pending nibble
    send("8", 1'b1);
    pulse_reset();
    chk("t6.rst_pend", 8'(ifa.pending), 8'h00);
    send("9", 1'b1);
    send("A", 1'b1);
    chk("t6.rst_data", ifa.out_data, 8'h9A);

    // Randomised traffic, with occasional long idle gaps and mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 199);
      bit rdy = ($urandom_range(0, 3) != 0);
      if (r == 0) idle($urandom_range(90, 110), rdy);
      else if (r == 1) pulse_reset();
      else if (r < 120) send(rand_char(), rdy);
      else step(1'b0, 8'($urandom_range(0, 255)), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_ascii_byte_rx.md
Name: hex_ascii_byte_rx

Overview:
Decodes a stream of ASCII hex characters from uart_rx into binary bytes. It is the inverse of the nibble-to-ASCII hex transmit path. It sits between uart_rx (uart_rx_valid/uart_rx_data) and a byte consumer. Two hex digits form one byte, high nibble first. A separator after a single digit completes the byte as 0x0N. Decoded bytes are presented on a valid/ready output register, and invalid characters and dropped bytes are flagged.

Parameters:
ALLOW_LOWERCASE, 1, 1: 'a'-'f' decode as 10-15; 0: they are invalid characters
TIMEOUT_CYCLES, 0, 0 disables; otherwise the number of clk cycles without in_valid after which a pending high nibble is discarded (max 2^24-1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle strobe, character available (driven by uart_rx_valid)
in_data  in  8  received character (driven by uart_rx_data)
out_valid  out  1  decoded byte available
out_ready  in  1  consumer accepts the byte when out_valid && out_ready at a rising edge
out_data  out  8  decoded byte
pending  out  1  high nibble held, waiting for the second digit
err_invalid  out  1  one-cycle pulse, invalid character received
err_overflow  out  1  one-cycle pulse, decoded byte dropped because the output register was full

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. Reset values: state EMPTY, nibble register 0, out_valid 0, out_data 0x00, pending 0, err_invalid 0, err_overflow 0, timeout counter 0. Asserting reset mid-operation loses any pending nibble and any held byte. No partial byte is emitted after reset.
- Character classes:
  - DIGIT: 0x30-0x39 decode to 0-9; 0x41-0x46 decode to 10-15; 0x61-0x66 decode to 10-15 when ALLOW_LOWERCASE=1.
  - SEP: 0x20, 0x09, 0x0D, 0x0A, 0x2C.
  - INVALID: everything else.
- in_data is sampled only in cycles where in_valid=1. Back-to-back in_valid cycles are legal and each is processed.
- FSM states: EMPTY, HAVE_HI. pending = (state==HAVE_HI).
- EMPTY transitions:
  - DIGIT: latch nibble, go to HAVE_HI.
  - SEP: ignore, stay.
  - INVALID: pulse err_invalid, stay.
- HAVE_HI transitions:
  - DIGIT: emit {hi, lo}, go to EMPTY.
  - SEP: emit {4'h0, hi}, go to EMPTY.
  - INVALID: discard hi, pulse err_invalid, go to EMPTY, no emit.
- Timeout: a counter clears on every in_valid and increments while in HAVE_HI. When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, discard hi and go to EMPTY with no emit and no error pulse. The counter holds at 0 in EMPTY. With TIMEOUT_CYCLES=0, HAVE_HI is held indefinitely.
- Emit latency: for in_valid sampled at edge N, out_valid=1 and out_data are valid after edge N. One cycle latency; no combinational path from in_* to out_*.
- Output register rules:
  - out_valid stays high and out_data stays stable until an edge with out_ready=1.
  - Emit with out_valid=0: load the byte.
  - Emit with out_valid=1 and out_ready=1 at the same edge: the old byte is consumed and the new byte loads; out_valid stays 1 and there is no error.
  - Emit with out_valid=1 and out_ready=0: the new byte is dropped, out_data is unchanged, and err_overflow pulses for one cycle.
  - out_valid=1 and out_ready=1 with no emit: out_valid goes to 0 and out_data holds its last value.
- err_invalid and err_overflow are registered, high for exactly one cycle after the triggering edge, and never both from the same character except as specified above.

Test Plan:
1. out_ready=1; in_valid strobes "4" (0x34) then "1" (0x31) -> pending=1 after the first strobe; one out_valid cycle with out_data=0x41 one cycle after the second strobe; pending=0.
2. With ALLOW_LOWERCASE=1, "a","F" -> out_data=0xAF. With ALLOW_LOWERCASE=0, "a" -> err_invalid pulse, pending=0; then "F","0" -> out_data=0xF0.
3. "7",0x0D -> out_data=0x07. A lone " " or "," in EMPTY -> no out_valid, no error.
4. "3","G" -> err_invalid pulse, no out_valid, pending=0; then "1","2" -> out_data=0x12.
5. out_ready=0; send "11" then "22" -> out_data=0x11 held with out_valid=1, err_overflow pulses once. Raise out_ready -> 0x11 accepted, out_valid=0. Send "33" while out_ready=1 coincides with a pending output -> no overflow, 0x33 appears.
6. TIMEOUT_CYCLES=100: "5" then 100 idle cycles -> pending=0, no emit; then "6","7" -> 0x67. Also: "8" then resetn pulsed low -> pending=0, out_valid=0; then "9","A" -> 0x9A.
